// File: rtl/add_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : add_share_arb_if
// Purpose  : Request/response bundle between operand producers, the shared
//            adder controller and the result consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface add_share_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int ID_W = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_par;

    // master = requesters plus consumer; slave = the arbitrated adder
    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_par
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_par
    );
endinterface
`default_nettype wire

// File: rtl/add_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : add_share_arb
// Purpose  : Round-robin arbiter sharing one W-bit ripple adder (yAdder1
//            cells) among NREQ requesters; capture / compute / respond FSM.
//            Optional parity output enabled by ADD_SHARE_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module yAdder1 (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_cin,
    output logic      o_z,
    output logic      o_cout
);
    assign o_z    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module add_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    add_share_arb_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_ptr;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_cin;
    logic [ID_W-1:0] r_id;

    logic [ID_W-1:0] r_rsp_id;
    logic [W-1:0]    r_rsp_sum;
    logic            r_rsp_cout;

    logic            w_found;
    logic [ID_W-1:0] w_win;
    logic [W-1:0]    w_a_sel;
    logic [W-1:0]    w_b_sel;
    logic            w_cin_sel;
    logic            w_grant;
    logic [ID_W-1:0] w_ptr_nxt;
    int              w_idx;

    // Rotating-priority search starting at r_ptr, then operand mux for the winner
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_a_sel   = '0;
        w_b_sel   = '0;
        w_cin_sel = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(w_idx);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == w_win) begin
                w_a_sel   = bus.req_a[i*W +: W];
                w_b_sel   = bus.req_b[i*W +: W];
                w_cin_sel = bus.req_cin[i];
            end
        end
    end

    assign w_grant   = (r_state == S_IDLE) && w_found;
    assign w_ptr_nxt = (w_win == ID_W'(NREQ-1)) ? '0 : w_win + ID_W'(1);

    // Gated by rst_n so no requester sees an accept while reset is held
    assign bus.req_ready = (w_grant && rst_n) ? (NREQ'(1) << w_win) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_ADD;
            S_ADD:   w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_a   <= w_a_sel;
                r_b   <= w_b_sel;
                r_cin <= w_cin_sel;
                r_id  <= w_win;
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    logic [W:0]   w_carry;
    logic [W-1:0] w_sum;

    assign w_carry[0] = r_cin;

    for (genvar g = 0; g < W; g++) begin : g_bit
        yAdder1 u_fa (
            .i_a    (r_a[g]),
            .i_b    (r_b[g]),
            .i_cin  (w_carry[g]),
            .o_z    (w_sum[g]),
            .o_cout (w_carry[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_id   <= '0;
            r_rsp_sum  <= '0;
            r_rsp_cout <= 1'b0;
        end else if (r_state == S_ADD) begin
            r_rsp_id   <= r_id;
            r_rsp_sum  <= w_sum;
            r_rsp_cout <= w_carry[W];
        end
    end

`ifdef ADD_SHARE_PARITY_EN
    logic r_rsp_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_rsp_par <= 1'b0;
        else if (r_state == S_ADD) r_rsp_par <= ^w_sum;
    end

    assign bus.rsp_par = r_rsp_par;
`else
    assign bus.rsp_par = 1'b0;
`endif

    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_cout  = r_rsp_cout;
endmodule
`default_nettype wire

// File: tb/tb_add_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_share_arb
// Purpose  : Directed plus randomized checks of add_share_arb against an
//            arithmetic / rotating-priority reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_share_arb;
    localparam int NREQ = 4;
    localparam int W    = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_ptr    = 0;
    int   win;
    int   exp_order [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    add_share_arb_if #(.NREQ(NREQ), .W(W)) ifc ();

    add_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++)
            if (mask[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic randomize_data();
        for (int i = 0; i < NREQ; i++) begin
            ifc.req_a[i*W +: W] = W'($urandom);
            ifc.req_b[i*W +: W] = W'($urandom);
            ifc.req_cin[i]      = 1'($urandom);
        end
    endtask

    // Entered at posedge+1 in IDLE with a nonzero mask; leaves at posedge+1 in IDLE
    task automatic run_txn(input int hold, output int w);
        logic [W-1:0] ea, eb;
        logic         ec;
        logic [W:0]   tot;
        logic         epar;
        ifc.rsp_ready = (hold == 0);
        #1;
        w = model_winner(ifc.req_valid);
        check("req_ready_onehot", 32'(ifc.req_ready), 32'(1) << w);
        ea  = ifc.req_a[w*W +: W];
        eb  = ifc.req_b[w*W +: W];
        ec  = ifc.req_cin[w];
        tot = (W+1)'(ea) + (W+1)'(eb) + (W+1)'(ec);
`ifdef ADD_SHARE_PARITY_EN
        epar = ^tot[W-1:0];
`else
        epar = 1'b0;
`endif
        @(posedge clk); #1;
        m_ptr = (w + 1) % NREQ;
        ifc.req_a[w*W +: W] = W'($urandom);
        ifc.req_b[w*W +: W] = W'($urandom);
        ifc.req_cin[w]      = 1'($urandom);
        check("add_req_ready", 32'(ifc.req_ready), 32'd0);
        check("add_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("rsp_valid",  32'(ifc.rsp_valid), 32'd1);
        check("rsp_id",     32'(ifc.rsp_id),    32'(w));
        check("rsp_sum",    32'(ifc.rsp_sum),   32'(tot[W-1:0]));
        check("rsp_cout",   32'(ifc.rsp_cout),  32'(tot[W]));
        check("rsp_par",    32'(ifc.rsp_par),   32'(epar));
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
            check("bp_rsp_sum",   32'(ifc.rsp_sum),   32'(tot[W-1:0]));
            check("bp_rsp_id",    32'(ifc.rsp_id),    32'(w));
            check("bp_req_ready", 32'(ifc.req_ready), 32'd0);
        end
        ifc.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("rsp_done", 32'(ifc.rsp_valid), 32'd0);
    endtask

    initial begin
        // Reset with every requester asserting
        rst_n         = 1'b0;
        ifc.req_valid = '1;
        ifc.rsp_ready = 1'b0;
        randomize_data();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(ifc.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(ifc.rsp_id),    32'd0);
        check("rst_rsp_sum",   32'(ifc.rsp_sum),   32'd0);
        check("rst_rsp_cout",  32'(ifc.rsp_cout),  32'd0);
        check("rst_rsp_par",   32'(ifc.rsp_par),   32'd0);
        ifc.req_valid = '0;
        rst_n = 1'b1;
        m_ptr = 0;
        @(posedge clk); #1;
        check("idle_no_req", 32'(ifc.req_ready), 32'd0);

        // Single request from requester 2
        ifc.req_valid        = 4'b0100;
        ifc.req_a[2*W +: W]  = 4'b1110;
        ifc.req_b[2*W +: W]  = 4'b0011;
        ifc.req_cin[2]       = 1'b0;
        run_txn(0, win);
        ifc.req_valid = '0;
        check("single_id",   32'(win),          32'd2);
        check("single_sum",  32'(ifc.rsp_sum),  32'h1);
        check("single_cout", 32'(ifc.rsp_cout), 32'd1);

        // Pointer now at 3: all-valid grants 3 first
        ifc.req_valid = '1;
        run_txn(0, win);
        check("ptr3_first", 32'(win), 32'd3);

        // Fresh reset, then continuous all-valid round robin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_ptr = 0;
        for (int t = 0; t < 5; t++) begin
            run_txn(0, win);
            check("rr_order", 32'(win), 32'(exp_order[t]));
        end

        // Backpressure for five cycles
        run_txn(5, win);

        // Carry / width corner on requester 1
        ifc.req_valid       = 4'b0010;
        ifc.req_a[1*W +: W] = 4'hF;
        ifc.req_b[1*W +: W] = 4'hF;
        ifc.req_cin[1]      = 1'b1;
        run_txn(0, win);
        check("carry_sum",  32'(ifc.rsp_sum),  32'hF);
        check("carry_cout", 32'(ifc.rsp_cout), 32'd1);
        check("carry_par",  32'(ifc.rsp_par),  32'd0);

        // Reset during ADD discards the operation
        ifc.req_valid = 4'b1010;
        ifc.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_add", 32'(ifc.req_ready), 32'd0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_ptr = 0;
        ifc.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("midrst_no_rsp", 32'(ifc.rsp_valid), 32'd0);
        end
        ifc.req_valid = 4'b1010;
        run_txn(0, win);
        check("midrst_lowest", 32'(win), 32'd1);

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            logic [NREQ-1:0] mask;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            ifc.req_valid = mask;
            if ($urandom_range(0, 1) == 1) randomize_data();
            run_txn(int'($urandom_range(0, 2)), win);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
